// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: bus command encodings, the
// arbiter sequencing states and the per-tag ownership record.
package mem_bus_arbiter_pkg;

  localparam int XLEN        = 32;
  localparam int CACHE_LINES = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    DRAIN
  } ARB_STATE;

  typedef enum logic {
    OWN_I,
    OWN_D
  } TAG_OWNER;

  typedef struct packed {
    logic     valid;
    TAG_OWNER owner;
  } TAG_ENTRY;

  // Which requester holds the memory port this cycle.
  typedef enum logic [1:0] {
    WIN_NONE,
    WIN_I,
    WIN_D,
    WIN_C
  } ARB_WINNER;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of every requester, memory and status signal around the arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic                   cleancache;
  logic [CACHE_LINES-1:0] dcache_empty;
  logic [1:0]             proc2Imem_command;
  logic [XLEN-1:0]        proc2Imem_addr;
  logic [1:0]             proc2Dmem_command;
  logic [XLEN-1:0]        proc2Dmem_addr;
  logic [63:0]            proc2Dmem_data;
  logic [1:0]             clean_command;
  logic [XLEN-1:0]        clean_addr;
  logic [63:0]            clean_data;
  logic [3:0]             mem2proc_response;
  logic [63:0]            mem2proc_data;
  logic [3:0]             mem2proc_tag;
  logic [1:0]             proc2mem_command;
  logic [XLEN-1:0]        proc2mem_addr;
  logic [63:0]            proc2mem_data;
  logic [3:0]             Imem2proc_response;
  logic [3:0]             Dmem2proc_response;
  logic [3:0]             Imem2proc_tag;
  logic [3:0]             Dmem2proc_tag;
  logic [63:0]            mem2proc_data_out;
  logic                   flush_done;
  logic                   tag_error;

  modport master (
    input  cleancache, dcache_empty,
    input  proc2Imem_command, proc2Imem_addr,
    input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    input  clean_command, clean_addr, clean_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output Imem2proc_response, Dmem2proc_response,
    output Imem2proc_tag, Dmem2proc_tag,
    output mem2proc_data_out, flush_done, tag_error
  );

  modport slave (
    output cleancache, dcache_empty,
    output proc2Imem_command, proc2Imem_addr,
    output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    output clean_command, clean_addr, clean_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  Imem2proc_response, Dmem2proc_response,
    input  Imem2proc_tag, Dmem2proc_tag,
    input  mem2proc_data_out, flush_done, tag_error
  );

endinterface

// File: rtl/mem_bus_arbiter_tag_owner_table.sv
// Ownership record for outstanding load tags. A set and a clear of the same
// index in one cycle leaves the entry set, so memory may reuse a freed tag.
module mem_bus_arbiter_tag_owner_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     set_en,
  input  logic [3:0] set_idx,
  input  TAG_OWNER set_owner,
  input  logic     clr_en,
  input  logic [3:0] clr_idx,
  input  logic [3:0] lookup_idx,
  output TAG_ENTRY lookup_entry,
  output logic     any_d
);

  TAG_ENTRY table_q [NUM_TAGS];
  TAG_ENTRY table_d [NUM_TAGS];

  // Apply the clear first so a same-index set overrides it.
  always_comb begin
    table_d = table_q;
    if (clr_en) table_d[clr_idx] = '0;
    if (set_en) table_d[set_idx] = '{valid: 1'b1, owner: set_owner};
  end

  // Table register; reset invalidates every entry.
  always_ff @(posedge clock) begin
    if (reset) table_q <= '{default: '0};
    else       table_q <= table_d;
  end

  assign lookup_entry = table_q[lookup_idx];

  // Any dcache load still in flight (entry 0 never carries a tag).
  always_comb begin
    any_d = 1'b0;
    for (int k = 1; k < NUM_TAGS; k++) begin
      if (table_q[k].valid && table_q[k].owner == OWN_D) any_d = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between icache fetch, dcache load/store and dcache
// clean writeback; routes responses and returned tags back to their owners
// and sequences the end-of-program clean (FLUSH, then DRAIN of D loads).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 16
) (
  input logic               clock,
  input logic               reset,
  mem_bus_arbiter_if.master bus
);

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  ARB_STATE         state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             tag_error_q, tag_error_d;
  ARB_WINNER        win;
  logic             i_act, d_act, c_act;
  logic             set_en, tag_hit, any_d;
  TAG_OWNER         set_owner;
  TAG_ENTRY         lookup_entry;

  assign i_act = bus.proc2Imem_command != BUS_NONE;
  assign d_act = bus.proc2Dmem_command != BUS_NONE;
  assign c_act = bus.clean_command     != BUS_NONE;

  // Pick this cycle's winner; a starved icache jumps ahead of the dcache once.
  always_comb begin
    win = WIN_NONE;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (i_act && (starve_q == LIMIT || !d_act)) win = WIN_I;
          else if (d_act)                             win = WIN_D;
        end
        FLUSH:   if (c_act) win = WIN_C;
        default: win = WIN_NONE;
      endcase
    end
  end

  // Forward the winner to memory and hand the immediate response back to it.
  always_comb begin
    bus.proc2mem_command   = BUS_NONE;
    bus.proc2mem_addr      = '0;
    bus.proc2mem_data      = '0;
    bus.Imem2proc_response = '0;
    bus.Dmem2proc_response = '0;
    unique case (win)
      WIN_I: begin
        bus.proc2mem_command   = bus.proc2Imem_command;
        bus.proc2mem_addr      = bus.proc2Imem_addr;
        bus.Imem2proc_response = bus.mem2proc_response;
      end
      WIN_D: begin
        bus.proc2mem_command   = bus.proc2Dmem_command;
        bus.proc2mem_addr      = bus.proc2Dmem_addr;
        bus.proc2mem_data      = bus.proc2Dmem_data;
        bus.Dmem2proc_response = bus.mem2proc_response;
      end
      WIN_C: begin
        bus.proc2mem_command   = bus.clean_command;
        bus.proc2mem_addr      = bus.clean_addr;
        bus.proc2mem_data      = bus.clean_data;
      end
      default: ;
    endcase
  end

  // Only accepted loads from a cache claim a tag; clean traffic never does.
  assign set_en = ((win == WIN_I && bus.proc2Imem_command == BUS_LOAD) ||
                   (win == WIN_D && bus.proc2Dmem_command == BUS_LOAD)) &&
                  bus.mem2proc_response != '0;
  assign set_owner = (win == WIN_I) ? OWN_I : OWN_D;

  assign tag_hit = !reset && bus.mem2proc_tag != '0 && lookup_entry.valid;

  assign bus.Imem2proc_tag = (tag_hit && lookup_entry.owner == OWN_I) ? bus.mem2proc_tag : '0;
  assign bus.Dmem2proc_tag = (tag_hit && lookup_entry.owner == OWN_D) ? bus.mem2proc_tag : '0;
  assign bus.mem2proc_data_out = bus.mem2proc_data;
  assign bus.tag_error         = tag_error_q;

  mem_bus_arbiter_tag_owner_table #(.NUM_TAGS(NUM_TAGS)) u_table (
    .clock        (clock),
    .reset        (reset),
    .set_en       (set_en),
    .set_idx      (bus.mem2proc_response),
    .set_owner    (set_owner),
    .clr_en       (tag_hit),
    .clr_idx      (bus.mem2proc_tag),
    .lookup_idx   (bus.mem2proc_tag),
    .lookup_entry (lookup_entry),
    .any_d        (any_d)
  );

  // Clean sequencing, starvation count and sticky orphan-tag flag.
  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    tag_error_d    = tag_error_q;
    bus.flush_done = 1'b0;
    unique case (state_q)
      IDLE:  if (bus.cleancache) state_d = FLUSH;
      FLUSH: if (bus.dcache_empty == '0 && !c_act) state_d = DRAIN;
      DRAIN: begin
        if (!any_d) begin
          state_d        = IDLE;
          bus.flush_done = !reset;
        end
      end
      default: state_d = IDLE;
    endcase
    if (i_act && win != WIN_I) starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + CNT_W'(1);
    else                       starve_d = '0;
    if (bus.mem2proc_tag != '0 && !lookup_entry.valid) tag_error_d = 1'b1;
  end

  // Control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      tag_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tag_error_q <= tag_error_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a cycle model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int LIM = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.STARVE_LIMIT(LIM), .NUM_TAGS(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: tag owners (0 free, 1 icache, 2 dcache), phase
  // (0 normal, 1 cleaning, 2 waiting for dcache loads), starve count, error.
  int m_own [16];
  int m_phase;
  int m_starve;
  bit m_err;

  int          e_win;
  logic [1:0]  e_cmd;
  logic [31:0] e_addr;
  logic [63:0] e_data;
  logic [3:0]  e_iresp, e_dresp, e_itag, e_dtag;
  logic        e_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    int nd = 0;
    int t;
    for (int k = 1; k < 16; k++) if (m_own[k] == 2) nd++;
    e_win = 0;
    if (!reset) begin
      if (m_phase == 0) begin
        if (bus.proc2Imem_command != 0 && (m_starve >= LIM || bus.proc2Dmem_command == 0)) e_win = 1;
        else if (bus.proc2Dmem_command != 0) e_win = 2;
      end else if (m_phase == 1 && bus.clean_command != 0) e_win = 3;
    end
    e_cmd = 0; e_addr = 0; e_data = 0; e_iresp = 0; e_dresp = 0;
    case (e_win)
      1: begin e_cmd = bus.proc2Imem_command; e_addr = bus.proc2Imem_addr; e_iresp = bus.mem2proc_response; end
      2: begin e_cmd = bus.proc2Dmem_command; e_addr = bus.proc2Dmem_addr; e_data = bus.proc2Dmem_data;
               e_dresp = bus.mem2proc_response; end
      3: begin e_cmd = bus.clean_command; e_addr = bus.clean_addr; e_data = bus.clean_data; end
      default: ;
    endcase
    t = int'(bus.mem2proc_tag);
    e_itag = (!reset && t != 0 && m_own[t] == 1) ? bus.mem2proc_tag : 4'd0;
    e_dtag = (!reset && t != 0 && m_own[t] == 2) ? bus.mem2proc_tag : 4'd0;
    e_done = !reset && m_phase == 2 && nd == 0;
  endtask

  task automatic model_update();
    int t;
    if (reset) begin
      for (int k = 0; k < 16; k++) m_own[k] = 0;
      m_phase = 0; m_starve = 0; m_err = 0;
    end else begin
      t = int'(bus.mem2proc_tag);
      if (t != 0) begin
        if (m_own[t] == 0) m_err = 1;
        else               m_own[t] = 0;
      end
      if (((e_win == 1 && bus.proc2Imem_command == BUS_LOAD) ||
           (e_win == 2 && bus.proc2Dmem_command == BUS_LOAD)) && bus.mem2proc_response != 0)
        m_own[bus.mem2proc_response] = e_win;
      if (bus.proc2Imem_command != 0 && e_win != 1) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
      else m_starve = 0;
      case (m_phase)
        0: if (bus.cleancache) m_phase = 1;
        1: if (bus.dcache_empty == 0 && bus.clean_command == 0) m_phase = 2;
        2: if (e_done) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic compare();
    check("proc2mem_command",   bus.proc2mem_command,   e_cmd);
    check("proc2mem_addr",      bus.proc2mem_addr,      e_addr);
    check("proc2mem_data",      bus.proc2mem_data,      e_data);
    check("Imem2proc_response", bus.Imem2proc_response, e_iresp);
    check("Dmem2proc_response", bus.Dmem2proc_response, e_dresp);
    check("Imem2proc_tag",      bus.Imem2proc_tag,      e_itag);
    check("Dmem2proc_tag",      bus.Dmem2proc_tag,      e_dtag);
    check("mem2proc_data_out",  bus.mem2proc_data_out,  bus.mem2proc_data);
    check("flush_done",         bus.flush_done,         e_done);
    check("tag_error",          bus.tag_error,          m_err);
  endtask

  task automatic settle();
    @(negedge clock);
    model_eval();
    compare();
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic quiet();
    bus.cleancache        = 1'b0;
    bus.dcache_empty      = 32'h1;
    bus.proc2Imem_command = BUS_NONE; bus.proc2Imem_addr = '0;
    bus.proc2Dmem_command = BUS_NONE; bus.proc2Dmem_addr = '0; bus.proc2Dmem_data = '0;
    bus.clean_command     = BUS_NONE; bus.clean_addr = '0;     bus.clean_data = '0;
    bus.mem2proc_response = '0; bus.mem2proc_data = 64'hDEAD_BEEF_0123_4567; bus.mem2proc_tag = '0;
  endtask

  task automatic dload(input logic [31:0] a, input logic [3:0] r);
    quiet();
    bus.proc2Dmem_command = BUS_LOAD; bus.proc2Dmem_addr = a; bus.mem2proc_response = r;
  endtask

  initial begin
    bit          rst_prev;
    int          t;
    logic [31:0] r32;

    quiet();
    reset = 1'b1;
    advance();
    settle();
    check("reset flush_done", bus.flush_done, 1'b0);
    check("reset tag_error", bus.tag_error, 1'b0);
    check("reset command", bus.proc2mem_command, BUS_NONE);
    advance();
    reset = 1'b0;
    step();

    // Same-cycle icache and dcache loads: dcache wins.
    quiet();
    bus.proc2Imem_command = BUS_LOAD; bus.proc2Imem_addr = 32'h100;
    bus.proc2Dmem_command = BUS_LOAD; bus.proc2Dmem_addr = 32'h200; bus.mem2proc_response = 4'd3;
    settle();
    check("dual addr", bus.proc2mem_addr, 32'h200);
    check("dual dresp", bus.Dmem2proc_response, 4'd3);
    check("dual iresp", bus.Imem2proc_response, 4'd0);
    advance();
    quiet(); step();

    // Starvation: four denials, then the icache gets the port.
    quiet();
    bus.proc2Imem_command = BUS_LOAD; bus.proc2Imem_addr = 32'h104;
    bus.proc2Dmem_command = BUS_LOAD; bus.proc2Dmem_addr = 32'h208;
    for (int c = 1; c <= 5; c++) begin
      settle();
      check("starve addr", bus.proc2mem_addr, (c == 5) ? 32'h104 : 32'h208);
      advance();
    end
    bus.proc2Imem_addr = 32'h108;
    settle();
    check("starve reset addr", bus.proc2mem_addr, 32'h208);
    advance();
    quiet(); step();

    // dcache load tag 5 returns ten cycles later.
    dload(32'h300, 4'd5);
    settle(); check("load5 dresp", bus.Dmem2proc_response, 4'd5); advance();
    quiet();
    for (int c = 0; c < 10; c++) step();
    bus.mem2proc_tag = 4'd5;
    settle();
    check("ret5 dtag", bus.Dmem2proc_tag, 4'd5);
    check("ret5 itag", bus.Imem2proc_tag, 4'd0);
    advance();
    bus.mem2proc_tag = 4'd3; step();
    quiet();
    settle(); check("ret5 tag_error", bus.tag_error, 1'b0); advance();

    // Orphan tag 7 sets a sticky error.
    bus.mem2proc_tag = 4'd7;
    settle();
    check("orphan itag", bus.Imem2proc_tag, 4'd0);
    check("orphan dtag", bus.Dmem2proc_tag, 4'd0);
    advance();
    quiet();
    for (int c = 0; c < 3; c++) begin
      settle(); check("orphan sticky", bus.tag_error, 1'b1); advance();
    end

    // Clean sequence with dcache tag 2 outstanding.
    reset = 1'b1; step(); reset = 1'b0;
    dload(32'h400, 4'd2); step();
    quiet(); bus.cleancache = 1'b1; step();
    for (int c = 0; c < 3; c++) begin
      quiet();
      bus.clean_command = BUS_STORE; bus.clean_addr = 32'h500 + 32'(c * 8);
      bus.clean_data = 64'(c + 1); bus.mem2proc_response = 4'(c + 9);
      bus.proc2Dmem_command = BUS_LOAD; bus.proc2Dmem_addr = 32'h480;
      settle();
      check("clean cmd", bus.proc2mem_command, BUS_STORE);
      check("clean addr", bus.proc2mem_addr, 32'h500 + 32'(c * 8));
      check("flush dresp", bus.Dmem2proc_response, 4'd0);
      advance();
    end
    quiet(); bus.dcache_empty = '0; step();
    quiet();
    settle(); check("drain wait", bus.flush_done, 1'b0); advance();
    bus.mem2proc_tag = 4'd2;
    settle(); check("drain ret2", bus.flush_done, 1'b0); advance();
    quiet();
    settle(); check("flush_done pulse", bus.flush_done, 1'b1); advance();
    dload(32'h600, 4'd0);
    settle();
    check("after flush done", bus.flush_done, 1'b0);
    check("after flush grant", bus.proc2mem_addr, 32'h600);
    advance();

    // Tag 4 freed and reallocated to the icache in one cycle.
    dload(32'h640, 4'd4); step();
    quiet();
    bus.proc2Imem_command = BUS_LOAD; bus.proc2Imem_addr = 32'h700;
    bus.mem2proc_response = 4'd4; bus.mem2proc_tag = 4'd4;
    settle();
    check("reuse dtag", bus.Dmem2proc_tag, 4'd4);
    check("reuse iresp", bus.Imem2proc_response, 4'd4);
    advance();
    quiet(); bus.mem2proc_tag = 4'd4;
    settle();
    check("reuse itag", bus.Imem2proc_tag, 4'd4);
    check("reuse dtag2", bus.Dmem2proc_tag, 4'd0);
    advance();

    // Reset during DRAIN.
    dload(32'h800, 4'd6); step();
    quiet(); bus.cleancache = 1'b1; step();
    quiet(); bus.dcache_empty = '0; step();
    settle(); check("drain hold", bus.flush_done, 1'b0); advance();
    reset = 1'b1; step(); reset = 1'b0;
    dload(32'h900, 4'd0); bus.mem2proc_tag = 4'd6;
    settle();
    check("post reset done", bus.flush_done, 1'b0);
    check("post reset grant", bus.proc2mem_addr, 32'h900);
    check("post reset dtag", bus.Dmem2proc_tag, 4'd0);
    advance();
    quiet();
    settle(); check("post reset table empty", bus.tag_error, 1'b1); advance();

    // Randomized traffic; losers hold their request until granted.
    rst_prev = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (rst_prev || e_win == 1 || bus.proc2Imem_command == BUS_NONE) begin
        bus.proc2Imem_command = ($urandom_range(0, 2) == 0) ? BUS_NONE : BUS_LOAD;
        bus.proc2Imem_addr    = $urandom;
      end
      if (rst_prev || e_win == 2 || bus.proc2Dmem_command == BUS_NONE) begin
        r32 = $urandom_range(0, 2);
        bus.proc2Dmem_command = r32[1:0];
        bus.proc2Dmem_addr    = $urandom;
        bus.proc2Dmem_data    = {$urandom, $urandom};
      end
      bus.clean_command     = ($urandom_range(0, 1) == 0) ? BUS_NONE : BUS_STORE;
      bus.clean_addr        = $urandom;
      bus.clean_data        = {$urandom, $urandom};
      bus.cleancache        = ($urandom_range(0, 39) == 0);
      bus.dcache_empty      = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      bus.mem2proc_response = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      bus.mem2proc_data     = {$urandom, $urandom};
      t = $urandom_range(1, 15);
      bus.mem2proc_tag      = (m_own[t] != 0 || $urandom_range(0, 19) == 0) ? 4'(t) : 4'd0;
      rst_prev = reset;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
